// File: rtl/host_device_bus_pkg.sv
// Shared helpers for the host/device interconnect.
package host_device_bus_pkg;

  // Index width for an N-entry selector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_prio_arb.sv
// Generic fixed-priority selector: lowest set request bit wins.
// Ports:
//   req_i     request vector
//   valid_c   any request present
//   onehot_c  one-hot grant of the winning bit
//   idx_c     binary index of the winning bit
module bus_prio_arb #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req_i,
  output logic            valid_c,
  output logic [N-1:0]    onehot_c,
  output logic [IdxW-1:0] idx_c
);

  // Isolate the lowest set bit (two's-complement trick).
  always_comb begin
    valid_c  = |req_i;
    onehot_c = req_i & (~req_i + N'(1));
  end

  // Scan high-to-low so the lowest index is written last and wins.
  always_comb begin
    idx_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_c = IdxW'(i);
    end
  end

endmodule

// File: rtl/host_device_bus.sv
// Single-cycle host/device interconnect with fixed-priority arbitration,
// base/mask address decode and one-cycle registered response routing.
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   host_req_i/host_gnt_o               host request / same-cycle grant
//   host_addr_i/we_i/be_i/wdata_i       host request payload
//   host_rvalid_o/rdata_o/err_o         host response (one cycle after grant)
//   device_req_o                        request to the decoded device
//   device_addr_o/we_o/be_o/wdata_o     winner payload broadcast to all devices
//   device_rvalid_i/rdata_i/err_i       device response
//   cfg_device_addr_base/mask           per-device decode window
module host_device_bus
  import host_device_bus_pkg::*;
#(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      host_req_i           [NrHosts],
  output logic                      host_gnt_o           [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
  input  logic                      host_we_i            [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
  output logic                      host_rvalid_o        [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
  output logic                      host_err_o           [NrHosts],

  output logic                      device_req_o         [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
  output logic                      device_we_o          [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
  input  logic                      device_rvalid_i      [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
  input  logic                      device_err_i         [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned HostIdxW = idx_width(NrHosts);
  localparam int unsigned DevIdxW  = idx_width(NrDevices);

  logic [NrHosts-1:0]      host_req_vec;
  logic [NrHosts-1:0]      host_gnt_vec;
  logic                    host_valid;
  logic [HostIdxW-1:0]     host_sel;

  logic [NrDevices-1:0]    dev_match;
  logic [NrDevices-1:0]    dev_onehot;
  logic                    dev_valid;
  logic [DevIdxW-1:0]      dev_sel;

  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BeWidth-1:0]      win_be;
  logic [DataWidth-1:0]    win_wdata;

  logic                    pend_q;
  logic                    unmapped_q;
  logic [HostIdxW-1:0]     host_q;
  logic [DevIdxW-1:0]      dev_q;

  logic                    resp_rvalid;
  logic [DataWidth-1:0]    resp_rdata;
  logic                    resp_err;

  // Flatten host requests for the arbiter.
  always_comb begin
    host_req_vec = '0;
    for (int unsigned h = 0; h < NrHosts; h++) host_req_vec[h] = host_req_i[h];
  end

  bus_prio_arb #(
    .N    (NrHosts),
    .IdxW (HostIdxW)
  ) u_host_arb (
    .req_i    (host_req_vec),
    .valid_c  (host_valid),
    .onehot_c (host_gnt_vec),
    .idx_c    (host_sel)
  );

  // Winner payload mux; all-zero when nobody requests.
  always_comb begin
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int unsigned h = 0; h < NrHosts; h++) begin
      if (host_gnt_vec[h]) begin
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  // Devices never stall, so every arbitration winner is granted.
  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) host_gnt_o[h] = host_gnt_vec[h];
  end

  // Gated by host_valid so an idle all-zero address cannot hit a device.
  always_comb begin
    dev_match = '0;
    for (int unsigned d = 0; d < NrDevices; d++) begin
      dev_match[d] = host_valid &&
                     ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]);
    end
  end

  bus_prio_arb #(
    .N    (NrDevices),
    .IdxW (DevIdxW)
  ) u_dev_arb (
    .req_i    (dev_match),
    .valid_c  (dev_valid),
    .onehot_c (dev_onehot),
    .idx_c    (dev_sel)
  );

  // Request to the decoded device; payload broadcast to all.
  always_comb begin
    for (int unsigned d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = dev_onehot[d];
      device_addr_o[d]  = win_addr;
      device_we_o[d]    = win_we;
      device_be_o[d]    = win_be;
      device_wdata_o[d] = win_wdata;
    end
  end

  // Response selection captured on every grant; pend_q marks the response cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= 1'b0;
      unmapped_q <= 1'b0;
      host_q     <= '0;
      dev_q      <= '0;
    end else begin
      pend_q     <= host_valid;
      unmapped_q <= host_valid & ~dev_valid;
      if (host_valid) begin
        host_q <= host_sel;
        dev_q  <= dev_sel;
      end
    end
  end

  // Pick the registered device's response, or synthesize an error if unmapped.
  always_comb begin
    resp_rvalid = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    if (unmapped_q) begin
      resp_rvalid = 1'b1;
      resp_err    = 1'b1;
    end else begin
      for (int unsigned d = 0; d < NrDevices; d++) begin
        if (dev_q == DevIdxW'(d)) begin
          resp_rvalid = device_rvalid_i[d];
          resp_rdata  = device_rdata_i[d];
          resp_err    = device_err_i[d];
        end
      end
    end
  end

  // Only the registered host sees the response; everyone else is held at zero.
  always_comb begin
    for (int unsigned h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = 1'b0;
      host_rdata_o[h]  = '0;
      host_err_o[h]    = 1'b0;
      if (pend_q && (host_q == HostIdxW'(h))) begin
        host_rvalid_o[h] = resp_rvalid;
        host_rdata_o[h]  = resp_rdata;
        host_err_o[h]    = resp_err;
      end
    end
  end

endmodule

// File: tb/tb_host_device_bus.sv
// Directed scoreboard bench for host_device_bus with two hosts and the
// Ram / SimCtrl / Timer device map.
module tb_host_device_bus;

  localparam int NH = 2;
  localparam int ND = 3;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst_n;

  logic        host_req    [NH];
  logic        host_gnt    [NH];
  logic [31:0] host_addr   [NH];
  logic        host_we     [NH];
  logic [3:0]  host_be     [NH];
  logic [31:0] host_wdata  [NH];
  logic        host_rvalid [NH];
  logic [31:0] host_rdata  [NH];
  logic        host_err    [NH];

  logic        dev_req     [ND];
  logic [31:0] dev_addr    [ND];
  logic        dev_we      [ND];
  logic [3:0]  dev_be      [ND];
  logic [31:0] dev_wdata   [ND];
  logic        dev_rvalid  [ND];
  logic [31:0] dev_rdata   [ND];
  logic        dev_err     [ND];
  logic [31:0] cfg_base    [ND];
  logic [31:0] cfg_mask    [ND];

  resp_t       sb [$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          pend_dev = -1;
  logic [31:0] pend_rdata = '0;
  logic        pend_err = 1'b0;
  int          txn_cnt = 0;

  host_device_bus #(
    .NrDevices    (ND),
    .NrHosts      (NH),
    .DataWidth    (32),
    .AddressWidth (32)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .host_req_i           (host_req),
    .host_gnt_o           (host_gnt),
    .host_addr_i          (host_addr),
    .host_we_i            (host_we),
    .host_be_i            (host_be),
    .host_wdata_i         (host_wdata),
    .host_rvalid_o        (host_rvalid),
    .host_rdata_o         (host_rdata),
    .host_err_o           (host_err),
    .device_req_o         (dev_req),
    .device_addr_o        (dev_addr),
    .device_we_o          (dev_we),
    .device_be_o          (dev_be),
    .device_wdata_o       (dev_wdata),
    .device_rvalid_i      (dev_rvalid),
    .device_rdata_i       (dev_rdata),
    .device_err_i         (dev_err),
    .cfg_device_addr_base (cfg_base),
    .cfg_device_addr_mask (cfg_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference map written as address ranges.
  function automatic int model_decode(input logic [31:0] a);
    if (a >= 32'h0010_0000 && a <= 32'h001F_FFFF) return 0;
    if (a >= 32'h0002_0000 && a <= 32'h0002_03FF) return 1;
    if (a >= 32'h0003_0000 && a <= 32'h0003_03FF) return 2;
    return -1;
  endfunction

  task automatic set_host(input int h, input logic r, input logic [31:0] a,
                          input logic w, input logic [3:0] b, input logic [31:0] wd);
    host_req[h]   = r;
    host_addr[h]  = a;
    host_we[h]    = w;
    host_be[h]    = b;
    host_wdata[h] = wd;
  endtask

  task automatic clear_dev_resp();
    for (int d = 0; d < ND; d++) begin
      dev_rvalid[d] = 1'b0;
      dev_rdata[d]  = '0;
      dev_err[d]    = 1'b0;
    end
  endtask

  // One bus cycle: drive device answers for last cycle's request, check the
  // routed response and this cycle's request side, then queue the expectation.
  task automatic step(input logic nxt_err, input logic stray);
    resp_t e;
    int    win;
    int    dec;
    clear_dev_resp();
    if (pend_dev >= 0) begin
      dev_rvalid[pend_dev] = 1'b1;
      dev_rdata[pend_dev]  = pend_rdata;
      dev_err[pend_dev]    = pend_err;
    end
    if (stray) begin
      dev_rvalid[0] = 1'b1;
      dev_rdata[0]  = 32'hDEAD_BEEF;
      dev_err[0]    = 1'b1;
    end
    #1;
    e.host = -1; e.rdata = '0; e.err = 1'b0;
    if (sb.size() > 0) e = sb.pop_front();
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("rvalid[%0d]", h), 32'(host_rvalid[h]), 32'(e.host == h));
      chk($sformatf("rdata[%0d]", h), host_rdata[h], (e.host == h) ? e.rdata : 32'h0);
      chk($sformatf("err[%0d]", h), 32'(host_err[h]), (e.host == h) ? 32'(e.err) : 32'h0);
    end
    win = -1;
    for (int h = NH - 1; h >= 0; h--) if (host_req[h]) win = h;
    dec = (win >= 0) ? model_decode(host_addr[win]) : -1;
    for (int h = 0; h < NH; h++)
      chk($sformatf("gnt[%0d]", h), 32'(host_gnt[h]), 32'(h == win));
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("dev_req[%0d]", d), 32'(dev_req[d]), 32'(win >= 0 && d == dec));
      chk($sformatf("dev_addr[%0d]", d), dev_addr[d], (win >= 0) ? host_addr[win] : 32'h0);
      chk($sformatf("dev_wdata[%0d]", d), dev_wdata[d], (win >= 0) ? host_wdata[win] : 32'h0);
      chk($sformatf("dev_we[%0d]", d), 32'(dev_we[d]), (win >= 0) ? 32'(host_we[win]) : 32'h0);
      chk($sformatf("dev_be[%0d]", d), 32'(dev_be[d]), (win >= 0) ? 32'(host_be[win]) : 32'h0);
    end
    pend_dev = -1;
    if (win >= 0) begin
      txn_cnt++;
      if (dec < 0) begin
        sb.push_back('{win, 32'h0, 1'b1});
      end else begin
        pend_dev   = dec;
        pend_rdata = 32'hD000_0000 | (32'(dec) << 16) | 32'(txn_cnt);
        pend_err   = nxt_err;
        sb.push_back('{win, pend_rdata, nxt_err});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    for (int h = 0; h < NH; h++) set_host(h, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    clear_dev_resp();
    rst_n = 1'b0;

    // Outputs quiet under reset.
    repeat (2) @(posedge clk);
    #1;
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("rst_rvalid[%0d]", h), 32'(host_rvalid[h]), 32'h0);
      chk($sformatf("rst_err[%0d]", h), 32'(host_err[h]), 32'h0);
      chk($sformatf("rst_gnt[%0d]", h), 32'(host_gnt[h]), 32'h0);
    end
    for (int d = 0; d < ND; d++)
      chk($sformatf("rst_dev_req[%0d]", d), 32'(dev_req[d]), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read RAM, write SimCtrl, Timer read with error, unmapped read.
    set_host(0, 1'b1, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
    step(1'b0, 1'b0);
    set_host(0, 1'b1, 32'h0002_0000, 1'b1, 4'hF, 32'h0000_0041);
    step(1'b0, 1'b0);
    set_host(0, 1'b1, 32'h0003_0004, 1'b0, 4'hF, 32'h0);
    step(1'b1, 1'b0);
    set_host(0, 1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
    step(1'b0, 1'b0);

    // Both hosts request; host1 holds until granted.
    set_host(0, 1'b1, 32'h0010_0080, 1'b0, 4'h3, 32'h0);
    set_host(1, 1'b1, 32'h0003_0010, 1'b1, 4'hC, 32'h1234_5678);
    step(1'b0, 1'b0);
    set_host(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step(1'b1, 1'b0);
    set_host(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step(1'b0, 1'b0);

    // Stray device response with nothing outstanding must not be routed.
    step(1'b0, 1'b1);

    // Host1 unmapped just above the SimCtrl window, then drain.
    set_host(1, 1'b1, 32'h0002_0400, 1'b0, 4'hF, 32'h0);
    step(1'b0, 1'b0);
    set_host(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step(1'b0, 1'b0);

    // Reset during the response cycle drops the response.
    set_host(0, 1'b1, 32'h0010_0040, 1'b0, 4'hF, 32'h0);
    step(1'b0, 1'b0);
    set_host(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    clear_dev_resp();
    dev_rvalid[0] = 1'b1;
    dev_rdata[0]  = pend_rdata;
    rst_n = 1'b0;
    #1;
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("midrst_rvalid[%0d]", h), 32'(host_rvalid[h]), 32'h0);
      chk($sformatf("midrst_rdata[%0d]", h), host_rdata[h], 32'h0);
    end
    sb.delete();
    pend_dev = -1;
    clear_dev_resp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0);

    // Recovery after reset.
    set_host(1, 1'b1, 32'h001F_FFFC, 1'b0, 4'hF, 32'h0);
    step(1'b0, 1'b0);
    set_host(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
